spi_reg_master: RTL

//   SPI initiator that issues single-register read/write frames to the SPI

---
 rtl/spi_reg_master.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/spi_reg_master.sv
// SPI register-frame initiator: one frame = command byte {rw, 3'b000, addr}
// followed by a data byte, MSB first, any of the four SPI modes.
// Optional build macro: SPI_MIN_GAP_EN inserts a CS_n-high GAP state of
// GAP_CYCLES clk cycles after every frame.
module spi_reg_master #(
    parameter int CLK_DIV    = 4,
    parameter int REG_WIDTH  = 8,
    parameter int GAP_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 rw,
    input  logic [3:0]           addr,
    input  logic [REG_WIDTH-1:0] wdata,
    input  logic                 cpol,
    input  logic                 cpha,
    output logic                 busy,
    output logic                 done,
    output logic [REG_WIDTH-1:0] rdata,
    output logic                 spi_cs_n,
    output logic                 spi_clk,
    output logic                 spi_mosi,
    input  logic                 spi_miso
);

    localparam int CNT_MAX = (CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam int FW      = 8 + REG_WIDTH;

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

    state_t         state, state_next;
    logic [CW-1:0]  cnt;
    logic           tick;
    logic [5:0]     edge_cnt;
    logic           cpol_q, cpha_q;
    logic           sclk;
    logic           mosi_q;
    logic           done_q;
    logic [FW-1:0]  tx;
    logic [REG_WIDTH-1:0] rx;
    logic [FW-1:0]  frame;
    logic           leading;
    logic           sample_ev;

    // Frame word, terminal-count strobe and the role of the next SCLK edge
    always_comb begin
        frame     = {rw, 3'b000, addr, rw ? wdata : {REG_WIDTH{1'b0}}};
        if (state == GAP)
            tick = (cnt == CW'(GAP_CYCLES - 1));
        else
            tick = (cnt == CW'(CLK_DIV - 1));
        // SCLK resting at the idle level means the next toggle is a leading edge
        leading   = (sclk == cpol_q);
        sample_ev = leading ^ cpha_q;
    end

    // State register and divider counter (counter restarts on every state change)
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state || tick)
                cnt <= '0;
            else
                cnt <= cnt + CW'(1);
        end
    end

    // Next-state decode
    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (start) state_next = SETUP;
            SETUP: if (tick) state_next = SHIFT;
            SHIFT: if (tick && edge_cnt == 6'd31) state_next = HOLD;
            HOLD: begin
                if (tick) begin
`ifdef SPI_MIN_GAP_EN
                    state_next = GAP;
`else
                    state_next = IDLE;
`endif
                end
            end
            GAP:   if (tick) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        busy     = (state != IDLE);
        spi_cs_n = (state == IDLE) || (state == GAP);
        spi_clk  = sclk;
        spi_mosi = mosi_q;
        done     = done_q;
    end

    // Datapath: capture request, drive SCLK/MOSI, collect MISO, publish rdata
    always_ff @(posedge clk) begin
        if (rst) begin
            cpol_q   <= 1'b0;
            cpha_q   <= 1'b0;
            sclk     <= 1'b0;
            mosi_q   <= 1'b0;
            done_q   <= 1'b0;
            edge_cnt <= '0;
            tx       <= '0;
            rx       <= '0;
            rdata    <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        cpol_q   <= cpol;
                        cpha_q   <= cpha;
                        sclk     <= cpol;
                        edge_cnt <= '0;
                        // CPHA=0 presents bit15 before the first edge; CPHA=1 waits for it
                        if (cpha) begin
                            mosi_q <= 1'b0;
                            tx     <= frame;
                        end else begin
                            mosi_q <= frame[FW-1];
                            tx     <= {frame[FW-2:0], 1'b0};
                        end
                    end
                end
                SHIFT: begin
                    if (tick) begin
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + 6'd1;
                        // rx is only one byte wide, so command-byte samples fall off the top
                        if (sample_ev) begin
                            rx <= {rx[REG_WIDTH-2:0], spi_miso};
                        end else begin
                            mosi_q <= tx[FW-1];
                            tx     <= {tx[FW-2:0], 1'b0};
                        end
                    end
                end
                HOLD: begin
                    if (tick) begin
                        done_q <= 1'b1;
                        rdata  <= rx;
                        mosi_q <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
